integrator_scheduler: RTL and testbench
=======================================

Name: integrator_scheduler

Overview:
Time-shares one integrator instance among NUM_CH sample sources. It grants channels round-robin, clears the integrator, and forwards exactly WIN_LEN handshaken samples from the granted channel. It then waits out the integrator latency, captures output_sum and presents it with the channel id on a valid/ready result port. It sits between the per-channel feature sources and the shared integrator in the gesture feature pipeline.

Parameters:
NUMBER_WIDTH, 16, sample and sum width (matches integrator)
NUM_CH, 4, number of requesting channels (2..8)
CH_W, 2, channel id width, clog2(NUM_CH)
WIN_LEN, 4, samples per integration window (1..255)
INTEG_LAT, 1, cycles from integrator input_valid to updated output_sum

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
ch_req  in  NUM_CH  channel i requests a window
ch_valid  in  NUM_CH  channel i sample valid
ch_data  in  NUM_CH*NUMBER_WIDTH  channel i sample at bits [i*W +: W]
ch_ready  out  NUM_CH  one-hot; sample accepted when ch_valid[i] & ch_ready[i]
integ_number  out  NUMBER_WIDTH  to integrator input_number (registered)
integ_valid  out  1  to integrator input_valid (registered)
integ_clear  out  1  to integrator synchronous clear, one-cycle pulse
integ_sum  in  NUMBER_WIDTH  from integrator output_sum
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  NUMBER_WIDTH  captured window sum
res_ch  out  CH_W  channel that produced res_data
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State becomes IDLE.
  - All outputs become 0: ch_ready, integ_*, res_*, busy.
  - last_grant becomes NUM_CH-1, so ch0 has top priority after reset.
  - Reset mid-window discards the window; no result is produced.
- IDLE:
  - If any ch_req is set, grant the first requesting channel, searching from last_grant+1 modulo NUM_CH.
  - Latch the grant and go to CLEAR. If no ch_req is set, stay in IDLE.
- CLEAR:
  - integ_clear=1 for exactly this cycle.
  - sample_cnt is set to 0.
  - Go to ACCUM.
- ACCUM:
  - ch_ready[grant]=1; all other ch_ready bits are 0. ch_valid and ch_data on non-granted channels are ignored.
  - On a handshake, the next cycle drives integ_number=ch_data[grant] and integ_valid=1. Otherwise integ_valid=0 and integ_number holds its value.
  - On the WIN_LEN-th handshake, drop ch_ready the same cycle the transfer is seen, load wait_cnt=INTEG_LAT+1, and go to WAIT.
  - Abort: if ch_req[grant]=0 in any ACCUM cycle with no handshake, go to IDLE and update last_grant=grant. No result is produced.
  - A handshake in the same cycle as a req drop is still accepted; abort is evaluated on the following cycle.
- WAIT:
  - wait_cnt decrements each cycle.
  - When wait_cnt reaches 0: res_data=integ_sum, res_ch=grant, res_valid=1, go to RESULT.
- RESULT:
  - res_valid, res_data and res_ch are held stable until res_ready=1.
  - On res_valid & res_ready: clear res_valid, set last_grant=grant, go to IDLE.
  - No new grant is issued while a result is pending.
- Latency: for an unstalled window, res_valid rises WIN_LEN+INTEG_LAT+3 cycles after the grant cycle in IDLE.
- Arithmetic: the sum wraps modulo 2^NUMBER_WIDTH, exactly as the integrator produces it. The scheduler applies no saturation.
- WIN_LEN=1 is legal: ACCUM accepts one sample and leaves.
- Sample bubbles (ch_valid low) extend ACCUM indefinitely; there is no timeout.
- Back-to-back operation: after RESULT→IDLE, a new grant may occur on the following cycle.

Test Plan:
Common setup: defaults, behavioural integrator model with clear.
1. Single window: ch0 req, valid with data=1 for 4 samples, res_ready=1 → integ_clear pulses once before the first integ_valid; exactly 4 integ_valid cycles; res_valid with res_data=4, res_ch=0.
2. Round-robin: ch0 and ch2 request continuously with data 2 and 3 → grant order 0,2,0,2; results 8,12,8,12.
3. Backpressure: res_ready=0 for 5 cycles while ch1 is also requesting → res_data/res_ch stable, ch_ready=0, busy=1; ch1 is granted only after the handshake.
4. Abort: ch1 drops req after 2 samples while ch2 requests → no res_valid for ch1; next grant is ch2 with a fresh clear; ch2 result is correct.
5. Reset mid-ACCUM: rst_n=0 for 1 cycle after 3 samples → next edge: all outputs 0, state IDLE; with ch0 and ch3 requesting, ch0 is granted first.
6. Wrap: ch3 sends 0x8000 x4 → res_data=0x0000, res_ch=3.

Source files
------------

// File: rtl/integrator_scheduler.sv
// ============================================================================
// integrator_scheduler : round-robin time-sharing of one integrator across
// NUM_CH sample channels, one WIN_LEN window per grant.   Rev 1.0
// ============================================================================
`default_nettype none

module integrator_scheduler #(
  parameter int NUMBER_WIDTH = 16,
  parameter int NUM_CH       = 4,
  parameter int CH_W         = 2,
  parameter int WIN_LEN      = 4,
  parameter int INTEG_LAT    = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH-1:0]              ch_valid,
  input  logic [NUM_CH*NUMBER_WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]              ch_ready,
  output logic [NUMBER_WIDTH-1:0]        integ_number,
  output logic                           integ_valid,
  output logic                           integ_clear,
  input  logic [NUMBER_WIDTH-1:0]        integ_sum,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [NUMBER_WIDTH-1:0]        res_data,
  output logic [CH_W-1:0]                res_ch,
  output logic                           busy
);

  localparam int WAIT_W = $clog2(INTEG_LAT + 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_ACCUM  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  localparam logic [7:0]        C_LAST_SAMPLE = 8'(WIN_LEN - 1);
  localparam logic [WAIT_W-1:0] C_WAIT_LOAD   = WAIT_W'(INTEG_LAT + 1);
  localparam logic [CH_W-1:0]   C_LAST_CH     = CH_W'(NUM_CH - 1);

  logic [2:0]              state_q,        state_d;
  logic [CH_W-1:0]         grant_q,        grant_d;
  logic [CH_W-1:0]         last_grant_q,   last_grant_d;
  logic [7:0]              sample_cnt_q,   sample_cnt_d;
  logic [WAIT_W-1:0]       wait_cnt_q,     wait_cnt_d;
  logic [NUMBER_WIDTH-1:0] integ_number_q, integ_number_d;
  logic                    integ_valid_q,  integ_valid_d;
  logic                    res_valid_q,    res_valid_d;
  logic [NUMBER_WIDTH-1:0] res_data_q,     res_data_d;
  logic [CH_W-1:0]         res_ch_q,       res_ch_d;

  logic [NUMBER_WIDTH-1:0] ch_word [NUM_CH];
  logic [CH_W-1:0]         arb_pick;
  logic [CH_W-1:0]         arb_idx;
  logic                    arb_found;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_word[g] = ch_data[g*NUMBER_WIDTH +: NUMBER_WIDTH];
  end

  // First requester at or after last_grant+1, wrapping modulo NUM_CH.
  always_comb begin
    arb_pick  = '0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      arb_idx = CH_W'((int'(last_grant_q) + 1 + k) % NUM_CH);
      if (!arb_found && ch_req[arb_idx]) begin
        arb_found = 1'b1;
        arb_pick  = arb_idx;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    sample_cnt_d   = sample_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    integ_number_d = integ_number_q;
    integ_valid_d  = 1'b0;
    res_valid_d    = res_valid_q;
    res_data_d     = res_data_q;
    res_ch_d       = res_ch_q;

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          grant_d = arb_pick;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        sample_cnt_d = '0;
        state_d      = S_ACCUM;
      end
      S_ACCUM: begin
        if (ch_valid[grant_q]) begin
          integ_valid_d  = 1'b1;
          integ_number_d = ch_word[grant_q];
          sample_cnt_d   = sample_cnt_q + 8'd1;
          if (sample_cnt_q == C_LAST_SAMPLE) begin
            wait_cnt_d = C_WAIT_LOAD;
            state_d    = S_WAIT;
          end
        end else if (!ch_req[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        // Capture on the 1->0 step so the result is registered as the count expires.
        if (wait_cnt_q == WAIT_W'(1)) begin
          res_data_d  = integ_sum;
          res_ch_d    = grant_q;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d  = 1'b0;
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      grant_q        <= '0;
      last_grant_q   <= C_LAST_CH;
      sample_cnt_q   <= '0;
      wait_cnt_q     <= '0;
      integ_number_q <= '0;
      integ_valid_q  <= 1'b0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_ch_q       <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      sample_cnt_q   <= sample_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      integ_number_q <= integ_number_d;
      integ_valid_q  <= integ_valid_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      res_ch_q       <= res_ch_d;
    end
  end

  assign ch_ready     = (state_q == S_ACCUM) ? (NUM_CH'(1) << grant_q) : '0;
  assign integ_clear  = (state_q == S_CLEAR);
  assign integ_number = integ_number_q;
  assign integ_valid  = integ_valid_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_ch       = res_ch_q;
  assign busy         = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_integrator_scheduler.sv
// Directed bench for integrator_scheduler with a behavioural integrator model.
`default_nettype none

module tb_integrator_scheduler;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int CW  = 2;
  localparam int WL  = 4;
  localparam int LAT = 1;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   ch_req;
  logic [N-1:0]   ch_valid;
  logic [N*W-1:0] ch_data;
  logic [N-1:0]   ch_ready;
  logic [W-1:0]   integ_number;
  logic           integ_valid;
  logic           integ_clear;
  logic [W-1:0]   integ_sum;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic [CW-1:0]  res_ch;
  logic           busy;

  int checks = 0;
  int errors = 0;

  integrator_scheduler #(
    .NUMBER_WIDTH(W), .NUM_CH(N), .CH_W(CW), .WIN_LEN(WL), .INTEG_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req(ch_req), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .integ_number(integ_number), .integ_valid(integ_valid), .integ_clear(integ_clear),
    .integ_sum(integ_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ch(res_ch),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integrator model: synchronous clear, one-cycle latency, wrapping sum.
  logic [W-1:0] model_sum = '0;
  always @(posedge clk) begin
    if (integ_clear)      model_sum <= '0;
    else if (integ_valid) model_sum <= model_sum + integ_number;
  end
  assign integ_sum = model_sum;

  typedef struct {
    logic [N-1:0]  req;
    logic [W-1:0]  d0, d1, d2, d3;
    logic [W-1:0]  exp_sum;
    logic [CW-1:0] exp_ch;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ch_ready"},     32'(ch_ready),     32'd0);
    chk({tag, "_integ_number"}, 32'(integ_number), 32'd0);
    chk({tag, "_integ_valid"},  32'(integ_valid),  32'd0);
    chk({tag, "_integ_clear"},  32'(integ_clear),  32'd0);
    chk({tag, "_res_valid"},    32'(res_valid),    32'd0);
    chk({tag, "_res_data"},     32'(res_data),     32'd0);
    chk({tag, "_res_ch"},       32'(res_ch),       32'd0);
    chk({tag, "_busy"},         32'(busy),         32'd0);
  endtask

  task automatic wait_clear(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (integ_clear) found = 1'b1;
    end
    chk({tag, "_clear_seen"}, 32'(found), 32'd1);
  endtask

  // Waits for res_valid, tallying clear/valid pulses and clear-to-result latency.
  task automatic wait_result(input string tag, input logic [CW-1:0] ech, input logic [W-1:0] esum);
    int  cyc = 0, clr_cyc = 0, nclr = 0, nval = 0, vbc = 0, lat = -1;
    bit  done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (integ_clear) begin nclr++; clr_cyc = cyc; end
      if (integ_valid) begin
        nval++;
        if (nclr == 0) vbc++;
      end
      if (res_valid) begin done = 1'b1; lat = cyc - clr_cyc; end
    end
    chk({tag, "_result_seen"},  32'(done), 32'd1);
    chk({tag, "_res_ch"},       32'(res_ch), 32'(ech));
    chk({tag, "_res_data"},     32'(res_data), 32'(esum));
    chk({tag, "_clear_pulses"}, 32'(nclr), 32'd1);
    chk({tag, "_valid_pulses"}, 32'(nval), 32'(WL));
    chk({tag, "_valid_b4_clr"}, 32'(vbc), 32'd0);
    chk({tag, "_latency"},      32'(lat), 32'(WL + LAT + 2));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0001, 16'd1,      16'd0,      16'd0,  16'd0,      16'd4,      2'd0};
    vecs[1] = '{4'b0101, 16'd2,      16'd0,      16'd3,  16'd0,      16'd12,     2'd2};
    vecs[2] = '{4'b0101, 16'd2,      16'd0,      16'd3,  16'd0,      16'd8,      2'd0};
    vecs[3] = '{4'b0101, 16'd2,      16'd0,      16'd3,  16'd0,      16'd12,     2'd2};
    vecs[4] = '{4'b0101, 16'd2,      16'd0,      16'd3,  16'd0,      16'd8,      2'd0};
    vecs[5] = '{4'b1000, 16'd0,      16'd0,      16'd0,  16'h8000,   16'h0000,   2'd3};
    vecs[6] = '{4'b1111, 16'h1234,   16'hFFFF,   16'd5,  16'd6,      16'h48D0,   2'd0};
    vecs[7] = '{4'b1111, 16'h1234,   16'hFFFF,   16'd5,  16'd6,      16'hFFFC,   2'd1};

    rst_n = 1'b0; ch_req = '0; ch_valid = '0; ch_data = '0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Continuous-request windows; grant order follows the round-robin pointer.
    for (int i = 0; i < 8; i++) begin
      ch_req   = vecs[i].req;
      ch_valid = '1;
      ch_data  = {vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0};
      wait_result($sformatf("v%0d", i), vecs[i].exp_ch, vecs[i].exp_sum);
    end
    ch_req = '0;
    @(negedge clk);

    // Result backpressure with a second requester waiting.
    res_ready = 1'b0;
    ch_req    = 4'b0011;
    ch_valid  = 4'b0011;
    ch_data   = {16'd0, 16'd0, 16'd7, 16'd5};
    wait_result("bp0", 2'd0, 16'd20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", i), 32'(res_valid), 32'd1);
      chk($sformatf("bp_hold%0d_data", i),  32'(res_data),  32'd20);
      chk($sformatf("bp_hold%0d_ch", i),    32'(res_ch),    32'd0);
      chk($sformatf("bp_hold%0d_ready", i), 32'(ch_ready),  32'd0);
      chk($sformatf("bp_hold%0d_busy", i),  32'(busy),      32'd1);
    end
    res_ready = 1'b1;
    wait_result("bp1", 2'd1, 16'd28);
    ch_req = '0;
    @(negedge clk);

    // Abort: ch1 drops its request after two samples, ch2 takes over.
    ch_req   = 4'b0010;
    ch_valid = '0;
    ch_data  = {16'd0, 16'h0010, 16'd9, 16'd0};
    wait_clear("ab");
    ch_valid = 4'b0010;
    repeat (3) @(negedge clk);
    chk("ab_second_sample", 32'(integ_valid), 32'd1);
    chk("ab_no_result",     32'(res_valid),   32'd0);
    chk("ab_ready_ch1",     32'(ch_ready),    32'b0010);
    ch_req   = 4'b0100;
    ch_valid = 4'b0100;
    wait_result("ab2", 2'd2, 16'h0040);
    ch_req = '0;
    @(negedge clk);

    // Reset in the middle of a ch3 window.
    ch_req   = 4'b1001;
    ch_valid = '1;
    ch_data  = {16'h0100, 16'd0, 16'd0, 16'd3};
    wait_clear("rs");
    repeat (4) @(negedge clk);
    chk("rs_ready_ch3", 32'(ch_ready), 32'b1000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_outputs("rs");
    wait_result("rs_after", 2'd0, 16'd12);
    ch_req = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
